// File: rtl/data_mem_mmio_pkg.sv
// Shared definitions for the data-side memory subsystem: bus widths, MMIO
// register indices, CSR bit positions and the access-target encoding.
package data_mem_mmio_pkg;

    localparam int unsigned DATA_ADDR_BUS = 32;
    localparam int unsigned DATA_WE_BUS   = 4;
    localparam int unsigned DATA_BUS      = 32;

    localparam logic [1:0] MMIO_LED_IDX = 2'd0;
    localparam logic [1:0] MMIO_CNT_IDX = 2'd1;
    localparam logic [1:0] MMIO_CMP_IDX = 2'd2;
    localparam logic [1:0] MMIO_CSR_IDX = 2'd3;

    localparam int unsigned CSR_IRQEN = 0;
    localparam int unsigned CSR_RUN   = 1;
    localparam int unsigned CSR_MATCH = 8;

    typedef enum logic [1:0] {
        TgtNone = 2'd0,
        TgtRam  = 2'd1,
        TgtMmio = 2'd2
    } tgt_e;

    // Replace only the byte lanes selected by be.
    function automatic logic [DATA_BUS-1:0] byte_merge(
        input logic [DATA_BUS-1:0]    old_val,
        input logic [DATA_BUS-1:0]    new_val,
        input logic [DATA_WE_BUS-1:0] be
    );
        logic [DATA_BUS-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(DATA_WE_BUS); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_mmio_if.sv
// Core data port as seen by the memory subsystem.
interface data_mem_mmio_if;
    import data_mem_mmio_pkg::*;

    logic [DATA_ADDR_BUS-1:0] daddr;
    logic                     dce;
    logic [DATA_WE_BUS-1:0]   we;
    logic [DATA_BUS-1:0]      din;
    logic [DATA_BUS-1:0]      dm;

    modport master (output daddr, dce, we, din, input dm);
    modport slave  (input daddr, dce, we, din, output dm);

endinterface

// File: rtl/data_sram.sv
// Byte-writable synchronous RAM; a read that hits the word being written
// returns the old contents.
module data_sram
    import data_mem_mmio_pkg::*;
#(
    parameter int unsigned RAM_AW = 10
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic [DATA_WE_BUS-1:0] we,
    input  logic [RAM_AW-1:0]      addr,
    input  logic [DATA_BUS-1:0]    wdata,
    output logic [DATA_BUS-1:0]    rdata
);

    logic [DATA_BUS-1:0] mem_q [2**RAM_AW];
    logic [DATA_BUS-1:0] rdata_q;

    // Read-first access: capture old word, then update the enabled lanes.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem_q[addr];
            for (int i = 0; i < int'(DATA_WE_BUS); i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory subsystem: decodes core accesses into data RAM, an MMIO
// window (LED + compare timer) or unmapped space; returns dm one cycle later.
module data_mem_mmio
    import data_mem_mmio_pkg::*;
#(
    parameter int unsigned RAM_AW    = 10,
    parameter logic [15:0] MMIO_BASE = 16'hBFD0,
    parameter logic [31:0] TIMER_RST = 32'h0
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst,
    data_mem_mmio_if.slave        bus,
    output logic [15:0]           led,
    output logic                  timer_irq
);

    logic                is_mmio;
    logic                is_ram;
    logic                ram_en;
    logic                mmio_wr;
    logic [1:0]          mmio_idx;
    logic [RAM_AW-1:0]   ram_idx;
    logic [DATA_BUS-1:0] ram_rdata;
    logic [DATA_BUS-1:0] csr_rd;
    logic                unused_addr_lsb;

    tgt_e                tgt_d, tgt_q;
    logic [DATA_BUS-1:0] mmio_rd_d, mmio_rd_q;
    logic [DATA_BUS-1:0] cnt_d, cnt_q;
    logic [DATA_BUS-1:0] cmp_d, cmp_q;
    logic [15:0]         led_d, led_q;
    logic                irq_en_d, irq_en_q;
    logic                run_d, run_q;
    logic                match_d, match_q;

    assign is_mmio  = (bus.daddr[31:16] == MMIO_BASE) && (bus.daddr[15:4] == 12'h0);
    assign is_ram   = (bus.daddr[DATA_ADDR_BUS-1:RAM_AW+2] == '0);
    assign mmio_idx = bus.daddr[3:2];
    assign ram_idx  = bus.daddr[RAM_AW+1:2];
    assign ram_en   = bus.dce && is_ram;
    assign mmio_wr  = bus.dce && is_mmio && (bus.we != '0);
    // Byte offset is meaningless for word accesses.
    assign unused_addr_lsb = ^bus.daddr[1:0];

    data_sram #(
        .RAM_AW (RAM_AW)
    ) u_sram (
        .clk   (cpu_clk_50M),
        .en    (ram_en),
        .we    (bus.we),
        .addr  (ram_idx),
        .wdata (bus.din),
        .rdata (ram_rdata)
    );

    // CSR read view assembled from its individual flag registers.
    always_comb begin
        csr_rd            = '0;
        csr_rd[CSR_IRQEN] = irq_en_q;
        csr_rd[CSR_RUN]   = run_q;
        csr_rd[CSR_MATCH] = match_q;
    end

    // Latch the access target and the pre-update MMIO read value.
    always_comb begin
        tgt_d     = tgt_q;
        mmio_rd_d = mmio_rd_q;
        if (bus.dce) begin
            if (is_mmio) begin
                tgt_d = TgtMmio;
                unique case (mmio_idx)
                    MMIO_LED_IDX: mmio_rd_d = {16'h0, led_q};
                    MMIO_CNT_IDX: mmio_rd_d = cnt_q;
                    MMIO_CMP_IDX: mmio_rd_d = cmp_q;
                    MMIO_CSR_IDX: mmio_rd_d = csr_rd;
                endcase
            end else if (is_ram) begin
                tgt_d = TgtRam;
            end else begin
                tgt_d = TgtNone;
            end
        end
    end

    // MMIO register next state; CPU writes override the free-running count.
    always_comb begin
        led_d    = led_q;
        cnt_d    = run_q ? cnt_q + 32'd1 : cnt_q;
        cmp_d    = cmp_q;
        irq_en_d = irq_en_q;
        run_d    = run_q;
        match_d  = match_q;
        if (mmio_wr) begin
            unique case (mmio_idx)
                MMIO_LED_IDX: begin
                    for (int i = 0; i < 2; i++) begin
                        if (bus.we[i]) begin
                            led_d[8*i +: 8] = bus.din[8*i +: 8];
                        end
                    end
                end
                MMIO_CNT_IDX: cnt_d = byte_merge(cnt_q, bus.din, bus.we);
                MMIO_CMP_IDX: cmp_d = byte_merge(cmp_q, bus.din, bus.we);
                MMIO_CSR_IDX: begin
                    if (bus.we[0]) begin
                        irq_en_d = bus.din[CSR_IRQEN];
                        run_d    = bus.din[CSR_RUN];
                    end
                    if (bus.we[1] && bus.din[CSR_MATCH]) begin
                        match_d = 1'b0;
                    end
                end
            endcase
        end
        // Set after clear so a coincident match beats the W1C.
        if (cnt_d == cmp_d) begin
            match_d = 1'b1;
        end
    end

    // State registers; RAM contents are deliberately outside reset.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            tgt_q     <= TgtNone;
            mmio_rd_q <= '0;
            led_q     <= '0;
            cnt_q     <= TIMER_RST;
            cmp_q     <= '1;
            irq_en_q  <= 1'b0;
            run_q     <= 1'b1;
            match_q   <= 1'b0;
        end else begin
            tgt_q     <= tgt_d;
            mmio_rd_q <= mmio_rd_d;
            led_q     <= led_d;
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            irq_en_q  <= irq_en_d;
            run_q     <= run_d;
            match_q   <= match_d;
        end
    end

    // Read-data mux steered by the registered target of the last access.
    always_comb begin
        case (tgt_q)
            TgtRam:  bus.dm = ram_rdata;
            TgtMmio: bus.dm = mmio_rd_q;
            default: bus.dm = '0;
        endcase
    end

    assign led       = led_q;
    assign timer_irq = match_q & irq_en_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed self-checking bench for data_mem_mmio.
module tb_data_mem_mmio;
    import data_mem_mmio_pkg::*;

    localparam logic [31:0] A_LED = 32'hBFD0_0000;
    localparam logic [31:0] A_CNT = 32'hBFD0_0004;
    localparam logic [31:0] A_CMP = 32'hBFD0_0008;
    localparam logic [31:0] A_CSR = 32'hBFD0_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] led;
    logic        irq;
    int          n_checks = 0;
    int          n_fail = 0;

    data_mem_mmio_if bus();

    data_mem_mmio dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .bus         (bus),
        .led         (led),
        .timer_irq   (irq)
    );

    always #5 clk = ~clk;

    // One-cycle access; returns 1 time unit after the access edge.
    task automatic acc(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        bus.daddr = a;
        bus.dce   = 1'b1;
        bus.we    = w;
        bus.din   = d;
        @(posedge clk);
        #1;
        bus.dce   = 1'b0;
        bus.we    = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if (bus.dm !== 32'h0) begin n_fail++; $display("FAIL reset_dm: got %h expected %h", bus.dm, 32'h0); end
        n_checks++;
        if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led: got %h expected %h", led, 16'h0); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected %b", irq, 1'b0); end
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ram_byte_en;
        acc(32'h10, 4'hF, 32'h1122_3344);
        acc(32'h10, 4'b0101, 32'hAABB_CCDD);
        n_checks++;
        if (bus.dm !== 32'h1122_3344) begin n_fail++; $display("FAIL ram_write_old: got %h expected %h", bus.dm, 32'h1122_3344); end
        acc(32'h10, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h11BB_33DD) begin n_fail++; $display("FAIL ram_be_read: got %h expected %h", bus.dm, 32'h11BB_33DD); end
    endtask

    task automatic test_read_first;
        acc(32'h20, 4'hF, 32'h0);
        acc(32'h20, 4'hF, 32'hDEAD_BEEF);
        n_checks++;
        if (bus.dm !== 32'h0) begin n_fail++; $display("FAIL read_first_old: got %h expected %h", bus.dm, 32'h0); end
        acc(32'h20, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_first_new: got %h expected %h", bus.dm, 32'hDEAD_BEEF); end
        bus.daddr = 32'h10;
        idle(2);
        n_checks++;
        if (bus.dm !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dce_low_hold: got %h expected %h", bus.dm, 32'hDEAD_BEEF); end
    endtask

    task automatic test_timer;
        acc(A_CNT, 4'hF, 32'd5);
        acc(A_CMP, 4'hF, 32'd8);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL timer_irq_early1: got %b expected %b", irq, 1'b0); end
        acc(A_CSR, 4'hF, 32'h3);
        n_checks++;
        if (bus.dm !== 32'h2) begin n_fail++; $display("FAIL csr_reset_read: got %h expected %h", bus.dm, 32'h2); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL timer_irq_early2: got %b expected %b", irq, 1'b0); end
        idle(1);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL timer_irq_rise: got %b expected %b", irq, 1'b1); end
        acc(A_CSR, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h103) begin n_fail++; $display("FAIL csr_match_read: got %h expected %h", bus.dm, 32'h103); end
        acc(A_CSR, 4'b0010, 32'h100);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_clear: got %b expected %b", irq, 1'b0); end
        acc(A_CSR, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h3) begin n_fail++; $display("FAIL csr_after_w1c: got %h expected %h", bus.dm, 32'h3); end
        acc(A_CNT, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'd11) begin n_fail++; $display("FAIL count_progress: got %0d expected %0d", bus.dm, 11); end
    endtask

    task automatic test_simultaneous;
        acc(A_CNT, 4'hF, 32'd8);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL match_on_cnt_write: got %b expected %b", irq, 1'b1); end
        acc(A_CNT, 4'hF, 32'd6);
        idle(1);
        acc(A_CSR, 4'b0010, 32'h100);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear: got %b expected %b", irq, 1'b1); end
        acc(A_CSR, 4'b0010, 32'h100);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_after_set: got %b expected %b", irq, 1'b0); end
        acc(A_CNT, 4'hF, 32'hFFFF_FFFF);
        acc(A_CNT, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cnt_written_max: got %h expected %h", bus.dm, 32'hFFFF_FFFF); end
        acc(A_CNT, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h0) begin n_fail++; $display("FAIL cnt_wrap: got %h expected %h", bus.dm, 32'h0); end
        acc(A_CNT, 4'b0001, 32'h1234_5678);
        acc(A_CNT, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h78) begin n_fail++; $display("FAIL cnt_byte_write_wins: got %h expected %h", bus.dm, 32'h78); end
        acc(A_CSR, 4'b0001, 32'h1);
        acc(A_CNT, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h7A) begin n_fail++; $display("FAIL cnt_stop: got %h expected %h", bus.dm, 32'h7A); end
        idle(3);
        acc(A_CNT, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h7A) begin n_fail++; $display("FAIL cnt_held: got %h expected %h", bus.dm, 32'h7A); end
        acc(A_CSR, 4'b0001, 32'h3);
    endtask

    task automatic test_led_unmapped;
        acc(A_LED, 4'hF, 32'h0000_A5A5);
        n_checks++;
        if (led !== 16'hA5A5) begin n_fail++; $display("FAIL led_write: got %h expected %h", led, 16'hA5A5); end
        acc(A_LED, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h0000_A5A5) begin n_fail++; $display("FAIL led_read: got %h expected %h", bus.dm, 32'h0000_A5A5); end
        acc(A_LED, 4'b0010, 32'h0000_3C00);
        n_checks++;
        if (led !== 16'h3CA5) begin n_fail++; $display("FAIL led_byte_en: got %h expected %h", led, 16'h3CA5); end
        acc(A_LED, 4'hF, 32'hFFFF_1234);
        acc(A_LED, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h0000_1234) begin n_fail++; $display("FAIL led_upper_zero: got %h expected %h", bus.dm, 32'h0000_1234); end
        acc(32'h0, 4'hF, 32'hCAFE_F00D);
        acc(32'h10, 4'h0, 32'h0);
        acc(32'h8000_0000, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected %h", bus.dm, 32'h0); end
        acc(32'h8000_0000, 4'hF, 32'h1234_5678);
        acc(32'h0000_1000, 4'hF, 32'h0000_0001);
        acc(32'hBFD0_0010, 4'hF, 32'h0000_0002);
        acc(32'h0, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL unmapped_write_dropped: got %h expected %h", bus.dm, 32'hCAFE_F00D); end
        acc(32'hBFD0_0010, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h0) begin n_fail++; $display("FAIL mmio_hole_read: got %h expected %h", bus.dm, 32'h0); end
        n_checks++;
        if (led !== 16'h1234) begin n_fail++; $display("FAIL mmio_hole_led: got %h expected %h", led, 16'h1234); end
        acc(32'h0000_0FFC, 4'hF, 32'h55AA_55AA);
        acc(32'h0000_0FFC, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h55AA_55AA) begin n_fail++; $display("FAIL ram_top_word: got %h expected %h", bus.dm, 32'h55AA_55AA); end
    endtask

    task automatic test_reset_mid;
        acc(A_CMP, 4'hF, 32'd1235);
        acc(A_CNT, 4'hF, 32'd1234);
        acc(32'h10, 4'h0, 32'h0);
        n_checks++;
        if (irq !== 1'b1 || bus.dm !== 32'h11BB_33DD) begin
            n_fail++;
            $display("FAIL pre_reset_state: got irq=%b dm=%h expected irq=1 dm=%h", irq, bus.dm, 32'h11BB_33DD);
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.dm !== 32'h0) begin n_fail++; $display("FAIL async_rst_dm: got %h expected %h", bus.dm, 32'h0); end
        n_checks++;
        if (led !== 16'h0) begin n_fail++; $display("FAIL async_rst_led: got %h expected %h", led, 16'h0); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL async_rst_irq: got %b expected %b", irq, 1'b0); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        acc(A_CNT, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'd1) begin n_fail++; $display("FAIL cnt_restart: got %h expected %h", bus.dm, 32'd1); end
        acc(A_CMP, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cmp_after_rst: got %h expected %h", bus.dm, 32'hFFFF_FFFF); end
        acc(A_CSR, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h2) begin n_fail++; $display("FAIL csr_after_rst: got %h expected %h", bus.dm, 32'h2); end
        acc(32'h10, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'h11BB_33DD) begin n_fail++; $display("FAIL ram_kept_10: got %h expected %h", bus.dm, 32'h11BB_33DD); end
        acc(32'h20, 4'h0, 32'h0);
        n_checks++;
        if (bus.dm !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_kept_20: got %h expected %h", bus.dm, 32'hDEAD_BEEF); end
    endtask

    initial begin
        bus.daddr = 32'h0;
        bus.dce   = 1'b0;
        bus.we    = 4'h0;
        bus.din   = 32'h0;
        test_reset();
        test_ram_byte_en();
        test_read_first();
        test_timer();
        test_simultaneous();
        test_led_unmapped();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
- Data-side memory subsystem directly downstream of the MiniMIPS32 core's data port.
- Consumes the core's daddr/dce/we/din and returns dm one cycle later, which the write-back stage samples.
- Decodes each access into one of three targets: a byte-writable synchronous data RAM, a small MMIO register window (LED register plus a compare timer with interrupt), or unmapped space.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM holds 2^RAM_AW 32-bit words, 4 KiB at default).
- MMIO_BASE, 16'hBFD0, value of daddr[31:16] that selects the MMIO window.
- TIMER_RST, 32'h0, reset value of the timer count register.

Ports:
- cpu_clk_50M  in  1  system clock; all state updates on the rising edge.
- cpu_rst  in  1  reset, asynchronous, active-high.
- daddr  in  32  byte address from the core's mem stage.
- dce  in  1  access enable; no access occurs when low.
- we  in  4  byte write enables; we[i] writes din[8i+7:8i] into byte i; 4'b0000 with dce=1 means read.
- din  in  32  store data, already lane-aligned by the core.
- dm  out  32  read data, registered.
- led  out  16  LED register contents.
- timer_irq  out  1  level interrupt = STATUS.match & CTRL.irq_en.

Behaviour:
- Address decode (combinational, from daddr):
  - MMIO when daddr[31:16]==MMIO_BASE and daddr[15:4]==0.
  - RAM when daddr[31:RAM_AW+2]==0.
  - Otherwise unmapped.
  - daddr[1:0] is ignored; the word index is daddr[RAM_AW+1:2] for RAM and daddr[3:2] for MMIO.
- Read latency is exactly 1 cycle.
  - If dce=1 at edge N, dm holds the addressed word after edge N (for the core's WB stage in cycle N+1).
  - If dce=0, dm holds its previous value.
  - Unmapped reads return 32'h0.
- Writes: dce=1 and we!=0 at an edge updates only the enabled bytes at that edge.
  - RAM read-during-write to the same word returns the OLD word (read-first).
  - Writes to unmapped space are dropped silently.
- MMIO map (word index):
  - 0 LED: RW; bits[15:0] drive led, upper bits read 0. Byte enables apply.
  - 1 COUNT: RW; increments by 1 every cycle and wraps 32'hFFFFFFFF -> 0. A CPU write in the same cycle wins: the enabled bytes take din, the other bytes take the pre-increment value with no increment.
  - 2 CMP: RW, reset 32'hFFFFFFFF.
  - 3 CTRL/STATUS:
    - bit0 irq_en: RW, reset 0.
    - bit1 run: RW, reset 1; COUNT only increments when run=1.
    - bit8 match: sticky; set when the post-update COUNT==CMP; write-1-to-clear through we[1] with din[8]=1; reads as the current value.
    - Other bits read 0.
    - If set and clear occur in the same cycle, set wins.
- MMIO reads return the register value before that edge's update (read-first, consistent with RAM).
- Reset (asynchronous, active-high):
  - Outputs: dm=0, led=0, timer_irq=0.
  - Registers: COUNT=TIMER_RST, CMP=all ones, irq_en=0, run=1, match=0.
  - RAM contents are not reset.
  - Reset asserted mid-access aborts the access: no partial write is guaranteed, and dm=0 until the first read after deassertion.
- No stall or handshake back to the core: every access completes in one cycle.

Decomposition:
- Shared package (the team's defines file):
  - Constants MMIO_LED_IDX=0, MMIO_CNT_IDX=1, MMIO_CMP_IDX=2, MMIO_CSR_IDX=3.
  - CSR bit positions (IRQEN=0, RUN=1, MATCH=8).
  - Reuse the existing DATA_ADDR_BUS / DATA_WE_BUS / DATA_BUS widths.
- One natural sub-module: data_sram, a byte-enable, read-first synchronous RAM (ports: clk, en, we[3:0], addr[RAM_AW-1:0], wdata, rdata).
- Decode, MMIO registers and the dm output mux stay in data_mem_mmio; the output mux selects on a registered target select.

Test Plan:
- Byte-enable RAM write then read:
  - Write 32'h11223344 at 0x10 with we=4'hF, then write din=32'hAABBCCDD with we=4'b0101.
  - Read 0x10 -> dm=32'h11BB33DD one cycle after the read edge.
- Read-first check:
  - Same-cycle write 32'hDEADBEEF and read at 0x20 previously holding 32'h0 -> dm=0.
  - Next read of 0x20 -> 32'hDEADBEEF.
- Timer compare and interrupt:
  - Write COUNT=5, CMP=8, CTRL=32'h3.
  - match and timer_irq rise at the edge where COUNT becomes 8 (3 edges after the COUNT write).
  - W1C write 32'h100 to CTRL/STATUS clears match unless COUNT==CMP again.
- Simultaneous events:
  - Write W1C on the same edge COUNT reaches CMP -> match stays 1.
  - CPU write COUNT=32'hFFFFFFFF then run -> next cycle COUNT=0 (wrap).
- Unmapped and LED accesses:
  - Write 32'h0000A5A5 to 0xBFD00000 -> led=16'hA5A5; read back -> 32'h0000A5A5.
  - Read 0x80000000 -> dm=0; write there leaves RAM word 0 unchanged.
- Reset mid-run:
  - Assert cpu_rst asynchronously between edges while COUNT=1234 -> immediately dm=0, led=0, timer_irq=0.
  - After release, COUNT restarts from TIMER_RST, and RAM contents are preserved.
